// File: rtl/encoder_emulator.sv
// Quadrature encoder emulator: emits an A/B step sequence at a programmable rate and
// direction, counts emitted steps, and double-buffers settings so changes land on step boundaries.
module encoder_emulator #(
    parameter int N_PERIOD   = 24,
    parameter int N_POSITION = 16
) (
    input  logic                  ENCODER_EMULATOR_CLOCK,
    input  logic                  ENCODER_EMULATOR_RESET_InLow,
    input  logic [N_PERIOD-1:0]   ENCODER_EMULATOR_PERIOD_InBus,
    input  logic                  ENCODER_EMULATOR_DIR_In,
    input  logic                  ENCODER_EMULATOR_LOAD_InLow,
    input  logic                  ENCODER_EMULATOR_ENABLE_InLow,
    output logic                  ENCODER_EMULATOR_ENCODERA_Out,
    output logic                  ENCODER_EMULATOR_ENCODERB_Out,
    output logic                  ENCODER_EMULATOR_EDGE_Out,
    output logic [N_POSITION-1:0] ENCODER_EMULATOR_POSITION_OutBus,
    output logic                  ENCODER_EMULATOR_PENDING_Out
);
    // state | meaning
    // PH_00 | A=0 B=0
    // PH_10 | A=1 B=0
    // PH_11 | A=1 B=1
    // PH_01 | A=0 B=1
    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_01 = 2'b01,
        PH_10 = 2'b10,
        PH_11 = 2'b11
    } phase_t;

    localparam logic [N_PERIOD-1:0]   PERIOD_ONE = N_PERIOD'(1);
    localparam logic [N_POSITION-1:0] POS_ONE    = N_POSITION'(1);

    phase_t                phase, phase_nxt;
    logic [N_PERIOD-1:0]   period_s, period_s_nxt;
    logic [N_PERIOD-1:0]   period_a, period_a_nxt;
    logic [N_PERIOD-1:0]   timer, timer_nxt;
    logic [N_POSITION-1:0] position, position_nxt;
    logic                  dir_s, dir_s_nxt;
    logic                  dir_a, dir_a_nxt;
    logic                  pending, pending_nxt;
    logic                  edge_r;
    logic                  load, enabled, running, step, transfer;

    assign load     = ~ENCODER_EMULATOR_LOAD_InLow;
    assign enabled  = ~ENCODER_EMULATOR_ENABLE_InLow;
    assign running  = (period_a != '0);
    assign step     = enabled && running && (timer == (period_a - PERIOD_ONE));
    // While running, settings only move on a step so no phase is ever shortened.
    assign transfer = enabled && pending && (step || !running);

    always_ff @(posedge ENCODER_EMULATOR_CLOCK or negedge ENCODER_EMULATOR_RESET_InLow) begin
        if (!ENCODER_EMULATOR_RESET_InLow) begin
            phase    <= PH_00;
            period_s <= '0;
            period_a <= '0;
            dir_s    <= 1'b0;
            dir_a    <= 1'b0;
            timer    <= '0;
            position <= '0;
            pending  <= 1'b0;
            edge_r   <= 1'b0;
        end else begin
            phase    <= phase_nxt;
            period_s <= period_s_nxt;
            period_a <= period_a_nxt;
            dir_s    <= dir_s_nxt;
            dir_a    <= dir_a_nxt;
            timer    <= timer_nxt;
            position <= position_nxt;
            pending  <= pending_nxt;
            edge_r   <= step;
        end
    end

    always_comb begin
        phase_nxt    = phase;
        period_s_nxt = period_s;
        period_a_nxt = period_a;
        dir_s_nxt    = dir_s;
        dir_a_nxt    = dir_a;
        timer_nxt    = timer;
        position_nxt = position;
        pending_nxt  = pending;

        if (enabled && running) begin
            timer_nxt = step ? '0 : timer + PERIOD_ONE;
        end

        // The step on a transfer edge still uses the old direction.
        if (step) begin
            if (!dir_a) begin
                case (phase)
                    PH_00: phase_nxt = PH_10;
                    PH_10: phase_nxt = PH_11;
                    PH_11: phase_nxt = PH_01;
                    PH_01: phase_nxt = PH_00;
                endcase
                position_nxt = position + POS_ONE;
            end else begin
                case (phase)
                    PH_00: phase_nxt = PH_01;
                    PH_01: phase_nxt = PH_11;
                    PH_11: phase_nxt = PH_10;
                    PH_10: phase_nxt = PH_00;
                endcase
                position_nxt = position - POS_ONE;
            end
        end

        if (transfer) begin
            period_a_nxt = period_s;
            dir_a_nxt    = dir_s;
            pending_nxt  = 1'b0;
            if (!running) begin
                timer_nxt = '0;
            end
        end

        // A load on the transfer edge re-arms pending with the newer value.
        if (load) begin
            period_s_nxt = ENCODER_EMULATOR_PERIOD_InBus;
            dir_s_nxt    = ENCODER_EMULATOR_DIR_In;
            pending_nxt  = 1'b1;
        end
    end

    assign ENCODER_EMULATOR_ENCODERA_Out    = phase[1];
    assign ENCODER_EMULATOR_ENCODERB_Out    = phase[0];
    assign ENCODER_EMULATOR_EDGE_Out        = edge_r;
    assign ENCODER_EMULATOR_POSITION_OutBus = position;
    assign ENCODER_EMULATOR_PENDING_Out     = pending;
endmodule

// File: tb/tb_encoder_emulator.sv
// Scoreboard bench for encoder_emulator: stimulus queues expected steps (cycle, AB, position),
// a negedge monitor pops one entry per EDGE pulse and flags any AB change without EDGE.
module tb_encoder_emulator;
    localparam int NP = 24;
    localparam int NQ = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [NP-1:0] period = '0;
    logic          dir = 1'b0;
    logic          load_n = 1'b1;
    logic          enable_n = 1'b0;
    logic          a_o, b_o, edge_o, pending_o;
    logic [NQ-1:0] pos_o;

    encoder_emulator #(.N_PERIOD(NP), .N_POSITION(NQ)) dut (
        .ENCODER_EMULATOR_CLOCK          (clk),
        .ENCODER_EMULATOR_RESET_InLow    (rst_n),
        .ENCODER_EMULATOR_PERIOD_InBus   (period),
        .ENCODER_EMULATOR_DIR_In         (dir),
        .ENCODER_EMULATOR_LOAD_InLow     (load_n),
        .ENCODER_EMULATOR_ENABLE_InLow   (enable_n),
        .ENCODER_EMULATOR_ENCODERA_Out   (a_o),
        .ENCODER_EMULATOR_ENCODERB_Out   (b_o),
        .ENCODER_EMULATOR_EDGE_Out       (edge_o),
        .ENCODER_EMULATOR_POSITION_OutBus(pos_o),
        .ENCODER_EMULATOR_PENDING_Out    (pending_o)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            at;
        logic [1:0]    ab;
        logic [NQ-1:0] pos;
        string         tag;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         failures = 0;
    logic [1:0] m_ab = 2'b00;
    int         m_pos = 0;
    logic [1:0] prev_ab = 2'b00;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [1:0] next_ab(logic [1:0] ab, bit d);
        logic [1:0] n;
        n = ab;
        if (!d) begin
            case (ab)
                2'b00: n = 2'b10;
                2'b10: n = 2'b11;
                2'b11: n = 2'b01;
                2'b01: n = 2'b00;
            endcase
        end else begin
            case (ab)
                2'b00: n = 2'b01;
                2'b01: n = 2'b11;
                2'b11: n = 2'b10;
                2'b10: n = 2'b00;
            endcase
        end
        return n;
    endfunction

    task automatic push_steps(string tag, int first, int p, int n, bit d);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            m_ab  = next_ab(m_ab, d);
            m_pos = d ? m_pos - 1 : m_pos + 1;
            e.at  = first + i * p;
            e.ab  = m_ab;
            e.pos = m_pos[NQ-1:0];
            e.tag = tag;
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (edge_o) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_edge: cycle %0d ab=%b pos=%0h, required no edge", cyc, {a_o, b_o}, pos_o);
                end else begin
                    e = q.pop_front();
                    check({e.tag, "_cycle"}, cyc, e.at);
                    check({e.tag, "_ab"}, {30'b0, a_o, b_o}, {30'b0, e.ab});
                    check({e.tag, "_pos"}, {28'b0, pos_o}, {28'b0, e.pos});
                end
            end else if ({a_o, b_o} != prev_ab) begin
                checks++;
                failures++;
                $display("FAIL ab_without_edge: cycle %0d ab=%b prev=%b, required edge pulse", cyc, {a_o, b_o}, prev_ab);
            end
        end
        prev_ab = {a_o, b_o};
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(int p, bit d);
        period = NP'(p);
        dir    = d;
        load_n = 1'b0;
        tick(1);
        load_n = 1'b1;
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_ab"}, {30'b0, a_o, b_o}, 32'h0);
        check({tag, "_pos"}, {28'b0, pos_o}, 32'h0);
        check({tag, "_pending"}, {31'b0, pending_o}, 32'h0);
        check({tag, "_edge"}, {31'b0, edge_o}, 32'h0);
    endtask

    // Asynchronous reset pulse asserted between clock edges, held across one negedge.
    task automatic pulse_reset(string tag);
        #3 rst_n = 1'b0;
        #1 check_reset_vals(tag);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_ab  = 2'b00;
        m_pos = 0;
    endtask

    int t;

    initial begin
        #1 rst_n = 1'b0;
        #2 check_reset_vals("por");
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(3);

        // basic cw run, P=4
        do_load(4, 0);
        t = cyc;
        check("cw_pending_set", {31'b0, pending_o}, 32'h1);
        push_steps("cw", t + 5, 4, 5, 0);
        tick(1);
        check("cw_pending_clr", {31'b0, pending_o}, 32'h0);
        tick(16);
        check("cw_ab_after4", {30'b0, a_o, b_o}, 32'h0);
        check("cw_pos_after4", {28'b0, pos_o}, 32'h4);
        do_load(0, 0);
        tick(3);
        check("cw_stop_pending", {31'b0, pending_o}, 32'h0);
        tick(8);

        // direction reversal at P=10
        do_load(10, 0);
        t = cyc;
        push_steps("rev", t + 11, 10, 2, 0);
        push_steps("rev", t + 31, 10, 2, 1);
        tick(11);
        check("rev_ab11", {30'b0, a_o, b_o}, 32'h3);
        do_load(10, 1);
        check("rev_pending_set", {31'b0, pending_o}, 32'h1);
        tick(8);
        check("rev_pending_hold", {31'b0, pending_o}, 32'h1);
        tick(1);
        check("rev_pending_clr", {31'b0, pending_o}, 32'h0);
        check("rev_old_dir_step", {30'b0, a_o, b_o}, 32'h1);
        tick(13);
        do_load(0, 1);
        tick(6);
        check("rev_pos", {28'b0, pos_o}, 32'h5);
        tick(6);

        // stop at P=3, resume at P=2
        do_load(3, 0);
        t = cyc;
        push_steps("stop", t + 4, 3, 2, 0);
        tick(4);
        do_load(0, 0);
        tick(8);
        check("stop_ab_hold", {30'b0, a_o, b_o}, 32'h1);
        check("stop_pos_hold", {28'b0, pos_o}, 32'h7);
        do_load(2, 0);
        t = cyc;
        push_steps("resume", t + 3, 2, 2, 0);
        tick(3);
        do_load(0, 0);
        tick(5);

        // enable freeze with P=8, frozen at timer=5
        do_load(8, 0);
        t = cyc;
        push_steps("freeze", t + 29, 8, 2, 0);
        tick(6);
        enable_n = 1'b1;
        tick(20);
        check("freeze_pos", {28'b0, pos_o}, 32'h9);
        check("freeze_ab", {30'b0, a_o, b_o}, 32'h2);
        enable_n = 1'b0;
        tick(4);
        do_load(0, 0);
        tick(10);

        // wrap and minimum period from reset, ccw
        pulse_reset("rst_pre_wrap");
        tick(2);
        do_load(1, 1);
        t = cyc;
        push_steps("wrap", t + 2, 1, 17, 1);
        tick(2);
        check("wrap_first_pos", {28'b0, pos_o}, 32'hF);
        check("wrap_first_ab", {30'b0, a_o, b_o}, 32'h1);
        tick(14);
        do_load(0, 1);
        check("wrap_pos_zero", {28'b0, pos_o}, 32'h0);
        check("wrap_ab_zero", {30'b0, a_o, b_o}, 32'h0);
        check("wrap_load_on_step", {31'b0, pending_o}, 32'h1);
        tick(1);
        check("wrap_pending_clr", {31'b0, pending_o}, 32'h0);
        tick(5);

        // reset mid-run at P=2 with a load pending
        do_load(2, 0);
        t = cyc;
        push_steps("midrst", t + 3, 2, 2, 0);
        tick(5);
        do_load(3, 0);
        check("midrst_pending_set", {31'b0, pending_o}, 32'h1);
        pulse_reset("midrst");
        tick(20);
        check("post_rst_ab", {30'b0, a_o, b_o}, 32'h0);
        check("post_rst_pos", {28'b0, pos_o}, 32'h0);

        check("queue_drained", q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/encoder_emulator.md
# encoder_emulator

Quadrature encoder emulator: generates the ChannelA/ChannelB pair that the wheel encoder counter consumes, at a programmable step rate and direction. It is the transmit side of the encoder interface. It drives the wheel-controller loop in simulation and hardware-in-the-loop rigs without a motor attached. It also keeps a signed step count, so a bench can check the controller's measured pulse count against the emitted count.

## Interface
Parameters:
- N_PERIOD, 24, width of the step-period field, in clock cycles per quadrature step (quarter cycle).
- N_POSITION, 16, width of the signed step counter.

Ports:
- ENCODER_EMULATOR_CLOCK  in  1  system clock, 50 MHz. This is the only clock.
- ENCODER_EMULATOR_RESET_InLow  in  1  reset. Asynchronous, active-low.
- ENCODER_EMULATOR_PERIOD_InBus  in  N_PERIOD  clocks per step. 0 means stopped.
- ENCODER_EMULATOR_DIR_In  in  1  0 = cw (A leads B), 1 = ccw (B leads A). Same convention as the encoder Dir output.
- ENCODER_EMULATOR_LOAD_InLow  in  1  when low at a rising edge, PERIOD and DIR are captured into the shadow registers.
- ENCODER_EMULATOR_ENABLE_InLow  in  1  low means stepping is allowed. High freezes the timer.
- ENCODER_EMULATOR_ENCODERA_Out  out  1  channel A, registered.
- ENCODER_EMULATOR_ENCODERB_Out  out  1  channel B, registered.
- ENCODER_EMULATOR_EDGE_Out  out  1  one-cycle pulse, high in the same cycle that A or B changes.
- ENCODER_EMULATOR_POSITION_OutBus  out  N_POSITION  signed two's-complement step count.
- ENCODER_EMULATOR_PENDING_Out  out  1  high while a loaded setting has not yet been applied.

## Operation
- Registers:
  - shadow (period_s, dir_s), updated by LOAD.
  - active (period_a, dir_a), the settings currently in use.
  - pending flag.
  - timer, N_PERIOD bits.
  - 2-bit phase state {A,B}.
  - position counter.
- Phase sequences:
  - cw (dir_a=0): AB 00→10→11→01→00.
  - ccw (dir_a=1): AB 00→01→11→10→00.
  - Exactly one channel changes per step, and the sequence never skips a state.
- Step condition, evaluated at every rising edge: ENABLE_InLow=0, period_a≠0 and timer==period_a−1.
- On a step:
  - the phase advances one state using dir_a;
  - timer←0;
  - position ±1 (+1 cw, −1 ccw), wrapping modulo 2^N_POSITION;
  - EDGE_Out=1 for that cycle.
- Otherwise, when enabled and period_a≠0, timer increments.
- Applying new settings:
  - Running (period_a≠0): the shadow is transferred to active only at a step edge. The step taken on that edge uses the old dir_a, and the new settings govern the following steps. Stepping is therefore glitch-free, with no runt phases.
  - Stopped (period_a=0): the shadow is transferred on the first enabled edge after pending is set, and timer←0.
  - Loading period 0 while running stops stepping at the next step boundary. A and B hold their levels.
- Loads are always accepted into the shadow, including while disabled. A later load overwrites an earlier pending one; last write wins.
- Disabled (ENABLE_InLow=1): timer, phase and position all hold, and no transfer occurs. When re-enabled, counting resumes from the held timer value.

## Timing
- Reset values, all applied immediately while RESET_InLow=0:
  - A=0, B=0, EDGE=0, POSITION=0, PENDING=0;
  - period_a=0, period_s=0, dir_a=0, dir_s=0, timer=0.
- From stopped, with LOAD at edge t and period P:
  - PENDING=1 after edge t;
  - activation at edge t+1, where PENDING→0 and timer=0;
  - first A/B change at edge t+1+P;
  - subsequent steps every P edges.
- Full quadrature cycle is 4P clocks. P=1 gives a step every clock.
- LOAD on the same edge as a step: the step transfers the previous shadow if pending; the new value is captured and PENDING stays or becomes 1.
- A direction reversal is applied at a boundary. The next step moves back to the previous state, and position changes sign direction.
- Reset asserted mid-operation forces all reset values asynchronously. After deassertion the block stays stopped until a new LOAD.

## Test plan
- **Basic cw run:** reset, then LOAD P=4, DIR=0, enable → first edge 5 clocks after LOAD; AB sequence 10,11,01,00 spaced 4 clocks; POSITION=4 after 16 clocks of stepping; EDGE pulses coincide with each change.
- **Direction reversal:** running cw at P=10 with AB=11, LOAD DIR=1 → PENDING=1 until the next step, which still goes to 01; the following step returns to 11 and POSITION decrements from then on.
- **Stop and resume:** running at P=3, LOAD P=0 → stepping stops at the next boundary and AB holds. Then LOAD P=2 → first edge 3 clocks later.
- **Enable freeze:** with P=8 and timer=5, hold ENABLE_InLow high for 20 clocks → no EDGE pulses and position unchanged; after release the next step occurs after 3 more clocks.
- **Wrap and minimum period:** N_POSITION=4, P=1, DIR=1 from reset → POSITION reads −1 (4'hF) after the first step; outputs toggle every clock; after 16 steps POSITION returns to 0 and AB returns to 00.
- **Reset mid-run:** at P=2, assert reset → A=B=0, POSITION=0 and PENDING=0 asynchronously; no steps after release until a new LOAD.
